// File: rtl/keystone_pkg.sv
// Shared constants and types for the keystone warp block.
// Holds the default geometry and slope settings, plus the bundle of raster timing bits.
package keystone_pkg;

    localparam int DEF_CENTER_X      = 492;
    localparam int DEF_ANCHOR_Y      = 560;
    localparam int DEF_SLOPE_FRAC    = 3;
    localparam int DEF_SLOPE_DEFAULT = 3;
    localparam int DEF_SLOPE_MAX     = 24;
    localparam int DEF_H_MAX         = 1023;

    // Timing bits that travel through the delay line beside the coordinates.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic bypass;
    } sync_t;

    localparam sync_t SYNC_RST = '{hsync: 1'b0, vsync: 1'b0, blank: 1'b1, bypass: 1'b0};

endpackage

// File: rtl/keystone_warp_if.sv
// Raster-in / corrected-raster-out bundle for keystone_warp.
// The master side drives the raster and slope requests. The slave side is the warp block.
interface keystone_warp_if #(
    parameter int H_W = 11,
    parameter int V_W = 10,
    parameter int S_W = 5
);
    logic [H_W-1:0] hcount;
    logic [V_W-1:0] vcount;
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic           slope_up;
    logic           slope_down;
    logic           bypass;

    logic [H_W-1:0] hcount_k;
    logic [V_W-1:0] vcount_k;
    logic           hsync_k;
    logic           vsync_k;
    logic           blank_k;
    logic [S_W-1:0] slope;
    logic           clipped;

    modport master (
        output hcount, vcount, hsync, vsync, blank, slope_up, slope_down, bypass,
        input  hcount_k, vcount_k, hsync_k, vsync_k, blank_k, slope, clipped
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, blank, slope_up, slope_down, bypass,
        output hcount_k, vcount_k, hsync_k, vsync_k, blank_k, slope, clipped
    );
endinterface

// File: rtl/keystone_slope_ctrl.sv
// Slope adjust control: rising-edge detection, saturating pending value, frame-synchronous apply.
// The applied slope changes only on a vsync rising edge, so every frame uses a single slope.
module keystone_slope_ctrl
    import keystone_pkg::*;
#(
    parameter int S_W           = 5,
    parameter int SLOPE_DEFAULT = DEF_SLOPE_DEFAULT,
    parameter int SLOPE_MAX     = DEF_SLOPE_MAX
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_up,
    input  logic           i_down,
    input  logic           i_vsync,
    output logic [S_W-1:0] o_slope
);
    logic           r_up_d, r_down_d, r_vsync_d;
    logic [S_W-1:0] r_pending, r_slope;
    logic [S_W-1:0] w_pending_nxt;
    logic           w_up_rise, w_down_rise, w_vsync_rise;

    assign w_up_rise    = i_up    & ~r_up_d;
    assign w_down_rise  = i_down  & ~r_down_d;
    assign w_vsync_rise = i_vsync & ~r_vsync_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_up_rise && !w_down_rise && (r_pending < S_W'(SLOPE_MAX)))
            w_pending_nxt = r_pending + 1'b1;
        else if (w_down_rise && !w_up_rise && (r_pending != '0))
            w_pending_nxt = r_pending - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_up_d    <= 1'b0;
            r_down_d  <= 1'b0;
            r_vsync_d <= 1'b0;
            r_pending <= S_W'(SLOPE_DEFAULT);
            r_slope   <= S_W'(SLOPE_DEFAULT);
        end else begin
            r_up_d    <= i_up;
            r_down_d  <= i_down;
            r_vsync_d <= i_vsync;
            r_pending <= w_pending_nxt;
            if (w_vsync_rise)
                r_slope <= r_pending;
        end
    end

    assign o_slope = r_slope;

endmodule

// File: rtl/keystone_warp.sv
// Keystone correction: shifts each column toward or away from CENTER_X by an amount that grows with distance from ANCHOR_Y.
// The pipeline has three stages: dy/side, multiply, then shift/add/clamp. Timing bits ride an equal delay line.
module keystone_warp
    import keystone_pkg::*;
#(
    parameter int H_W           = 11,
    parameter int V_W           = 10,
    parameter int S_W           = 5,
    parameter int SLOPE_FRAC    = DEF_SLOPE_FRAC,
    parameter int SLOPE_DEFAULT = DEF_SLOPE_DEFAULT,
    parameter int SLOPE_MAX     = DEF_SLOPE_MAX,
    parameter int CENTER_X      = DEF_CENTER_X,
    parameter int ANCHOR_Y      = DEF_ANCHOR_Y,
    parameter int H_MAX         = DEF_H_MAX
) (
    input  logic            clk,
    input  logic            reset,
    keystone_warp_if.slave  bus
);
    localparam int DW = V_W + 2;
    localparam int PW = DW + S_W + 1;
    localparam int RW = ((PW > H_W + 1) ? PW : H_W + 1) + 1;

    logic [S_W-1:0] w_slope;

    keystone_slope_ctrl #(
        .S_W           (S_W),
        .SLOPE_DEFAULT (SLOPE_DEFAULT),
        .SLOPE_MAX     (SLOPE_MAX)
    ) u_slope_ctrl (
        .clk     (clk),
        .reset   (reset),
        .i_up    (bus.slope_up),
        .i_down  (bus.slope_down),
        .i_vsync (bus.vsync),
        .o_slope (w_slope)
    );

    sync_t w_sync_in;
    assign w_sync_in = '{hsync: bus.hsync, vsync: bus.vsync, blank: bus.blank, bypass: bus.bypass};

    logic signed [DW-1:0] w_dy;
    logic                 w_left;
    assign w_dy   = DW'(ANCHOR_Y) - $signed({2'b00, bus.vcount});
    assign w_left = bus.hcount < H_W'(CENTER_X);

    logic signed [DW-1:0] r1_dy;
    logic                 r1_left, r2_left;
    logic [H_W-1:0]       r1_h, r2_h, r3_h;
    logic [V_W-1:0]       r1_v, r2_v, r3_v;
    sync_t                r1_sync, r2_sync, r3_sync;
    logic signed [PW-1:0] r2_prod;
    logic                 r3_clip;

    logic signed [PW-1:0] w_prod, w_off;
    logic signed [RW-1:0] w_h_ext, w_raw;
    logic [H_W-1:0]       w_h_k;
    logic                 w_clip;

    assign w_prod  = PW'(r1_dy) * PW'($signed({1'b0, w_slope}));
    // Arithmetic shift of a signed product rounds toward minus infinity.
    assign w_off   = r2_prod >>> SLOPE_FRAC;
    assign w_h_ext = $signed({{(RW - H_W){1'b0}}, r2_h});
    assign w_raw   = r2_left ? (w_h_ext - RW'(w_off)) : (w_h_ext + RW'(w_off));

    always_comb begin
        w_h_k  = r2_h;
        w_clip = 1'b0;
        if (!r2_sync.bypass) begin
            if (w_raw < 0) begin
                w_h_k  = '0;
                w_clip = 1'b1;
            end else if (w_raw > RW'(H_MAX)) begin
                w_h_k  = H_W'(H_MAX);
                w_clip = 1'b1;
            end else begin
                w_h_k  = w_raw[H_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r1_dy   <= '0;
            r1_left <= 1'b0;
            r1_h    <= '0;
            r1_v    <= '0;
            r1_sync <= SYNC_RST;
            r2_prod <= '0;
            r2_left <= 1'b0;
            r2_h    <= '0;
            r2_v    <= '0;
            r2_sync <= SYNC_RST;
            r3_h    <= '0;
            r3_v    <= '0;
            r3_sync <= SYNC_RST;
            r3_clip <= 1'b0;
        end else begin
            r1_dy   <= w_dy;
            r1_left <= w_left;
            r1_h    <= bus.hcount;
            r1_v    <= bus.vcount;
            r1_sync <= w_sync_in;
            r2_prod <= w_prod;
            r2_left <= r1_left;
            r2_h    <= r1_h;
            r2_v    <= r1_v;
            r2_sync <= r1_sync;
            r3_h    <= w_h_k;
            r3_v    <= r2_v;
            r3_sync <= '{hsync: r2_sync.hsync, vsync: r2_sync.vsync,
                         blank: r2_sync.blank | w_clip, bypass: r2_sync.bypass};
            r3_clip <= w_clip;
        end
    end

    assign bus.hcount_k = r3_h;
    assign bus.vcount_k = r3_v;
    assign bus.hsync_k  = r3_sync.hsync;
    assign bus.vsync_k  = r3_sync.vsync;
    assign bus.blank_k  = r3_sync.blank;
    assign bus.clipped  = r3_clip;
    assign bus.slope    = w_slope;

endmodule
